msg_split: RTL and testbench
============================

// Module: msg_split
// PURPOSE
//  Splits one merged byte stream back into two destination streams A and B.
//  Each message is a header byte plus payload bytes; the header names the destination and the length.
//  Sits on the receive side of a link, opposite the two-input arbitrating buffer.
//  Structure: input FIFO -> routing FSM -> per-destination output FIFOs.
// PARAMETERS
//  data_width  8   byte width; header bit [data_width-1] = dest, bits [data_width-2:0] = payload length L
//  adr_width   3   FIFO address bits; every FIFO depth DEPTH = 2**adr_width (default 8)
// PORTS
//  CLK        in   1    single clock, all logic rising-edge
//  RESET      in   1    asynchronous, active-high reset
//  I_DAT_EN   in   1    input byte strobe, one byte per cycle when high
//  I_DAT      in   dw   input byte
//  I_N_FULL   out  1    input FIFO nearly full; upstream stops writing next cycle
//  A_DAT_EN   out  1    A output byte valid (one-cycle pulse per byte)
//  A_DAT      out  dw   A output byte
//  A_BUSY     in   1    A sink busy; no A read issued while high
//  B_DAT_EN   out  1    B output byte valid
//  B_DAT      out  dw   B output byte
//  B_BUSY     in   1    B sink busy
//  OVF        out  1    one-cycle pulse: input byte dropped because input FIFO FULL
// BEHAVIOUR
//  Reset: all FIFO pointers/counts 0; FSM=IDLE; I_N_FULL, A_DAT_EN, B_DAT_EN, OVF = 0; A_DAT, B_DAT = 0.
//  FIFO rules (all three FIFOs identical):
//   - write when WDAT_EN & ~FULL; read when REN & ~EMPTY; RDAT/RDAT_EN registered, one cycle after REN.
//   - FULL = (count==DEPTH); EMPTY = (count==0); N_FULL = (count >= DEPTH-2), all from registered count.
//   - simultaneous read+write keeps count; pointers wrap modulo DEPTH.
//  Input: write with I_DAT_EN while FULL -> byte dropped, OVF pulses the next cycle.
//  Outputs: A FIFO REN = ~A_BUSY; B FIFO REN = ~B_BUSY. A_DAT_EN/B_DAT_EN equal the FIFO RDAT_EN.
//  Routing FSM (DEST reg 1b, CNT reg data_width-1 bits):
//   IDLE: if input ~EMPTY -> issue REN, go HDR.
//   HDR:  on RDAT_EN: DEST=hdr[msb], CNT=hdr[len]; header byte written to the DEST FIFO.
//         If L==0 -> IDLE, else -> PAY.
//   PAY:  issue REN when input ~EMPTY, DEST FIFO ~N_FULL and no read in flight; each returned byte
//         is written to the DEST FIFO and decrements CNT. Returned byte with CNT==1 -> IDLE.
//   - The header read in IDLE is also gated by ~N_FULL of both output FIFOs; this guarantees room.
//   - No more than one input read in flight, so peak rate is 1 byte / 2 cycles and no output write overflows.
//   - A stalled destination blocks the whole stream; the other FIFO still drains its contents.
//  Latency: header written at cycle t, sink idle, FSM IDLE -> appears on X_DAT_EN at t+4.
//  Messages are never interleaved or reordered; byte order within a message is preserved.
//  Max message = 1 + (2**(data_width-1)-1) bytes; longer FIFOs not required (flow-controlled).
//  RESET mid-message: all FIFOs flushed, FSM to IDLE, partial message discarded.
//  The next input byte after reset is treated as a header.
// TESTING
//  1 reset: assert RESET mid-PAY -> all outputs 0 same cycle; after release, hdr 0x01+0x55 -> A gets 01,55 only.
//  2 route: write 0x02,0xAA,0xBB then 0x81,0xCC -> A: 02,AA,BB; B: 81,CC; first A byte at write-cycle+4.
//  3 zero length: write 0x00 then 0x80 -> A gets 00 alone, B gets 80 alone; FSM returns IDLE each time.
//  4 backpressure: A_BUSY=1, send 0x7F+127 bytes -> A FIFO holds <=DEPTH, no loss.
//    Release A_BUSY -> all 128 bytes out in order.
//  5 overflow: A_BUSY=1, burst 12 bytes ignoring I_N_FULL -> OVF pulses per dropped byte, FIFO count stays 8.
//  6 blocking: A stalled mid-message, then B message queued -> no B output until A message completes.

Source files
------------

// File: rtl/msg_split.sv
// msg_split: splits one merged byte stream into two destination streams A and B.
// Each message is one header byte followed by L payload bytes. The header MSB selects
// the destination (0 = A, 1 = B) and the remaining bits give L. The header byte is
// forwarded together with its payload.
// Data path: input FIFO -> routing FSM -> per-destination output FIFOs.
// Ports:
//   CLK, RESET          rising-edge clock, asynchronous active-high reset
//   I_DAT_EN, I_DAT     input byte strobe and data
//   I_N_FULL            input FIFO nearly full; upstream stops writing
//   A_DAT_EN, A_DAT     A output byte pulse and data; A_BUSY stalls A reads
//   B_DAT_EN, B_DAT     B output byte pulse and data; B_BUSY stalls B reads
//   OVF                 one-cycle pulse when an input byte was dropped on a full FIFO
module msg_split #(
    parameter int unsigned data_width = 8,
    parameter int unsigned adr_width  = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_DAT_EN,
    input  logic [data_width-1:0] I_DAT,
    output logic                  I_N_FULL,
    output logic                  A_DAT_EN,
    output logic [data_width-1:0] A_DAT,
    input  logic                  A_BUSY,
    output logic                  B_DAT_EN,
    output logic [data_width-1:0] B_DAT,
    input  logic                  B_BUSY,
    output logic                  OVF
);

    localparam int unsigned DEPTH = 2 ** adr_width;
    localparam int unsigned LenW  = data_width - 1;
    localparam logic [adr_width:0] CntFull  = (adr_width + 1)'(DEPTH);
    localparam logic [adr_width:0] CntNFull = (adr_width + 1)'(DEPTH - 2);

    // FIFO index 0 = input, 1 = A, 2 = B
    logic [2:0]                  wen, ren, full, empty, n_full, rdat_en;
    logic [2:0][data_width-1:0]  wdat, rdat;
    logic [2:0][adr_width:0]     fifo_cnt;

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        logic [data_width-1:0] mem_q [DEPTH];
        logic [adr_width-1:0]  wptr_q, rptr_q;
        logic [adr_width:0]    cnt_q;
        logic [data_width-1:0] rdat_q;
        logic                  rdat_en_q;
        logic                  do_wr, do_rd;

        assign full[g]     = (cnt_q == CntFull);
        assign empty[g]    = (cnt_q == '0);
        assign n_full[g]   = (cnt_q >= CntNFull);
        assign do_wr       = wen[g] & ~full[g];
        assign do_rd       = ren[g] & ~empty[g];
        assign rdat[g]     = rdat_q;
        assign rdat_en[g]  = rdat_en_q;
        assign fifo_cnt[g] = cnt_q;

        // Storage is not reset; pointers and count define validity.
        always_ff @(posedge CLK) begin
            if (do_wr) mem_q[wptr_q] <= wdat[g];
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                wptr_q    <= '0;
                rptr_q    <= '0;
                cnt_q     <= '0;
                rdat_q    <= '0;
                rdat_en_q <= 1'b0;
            end else begin
                rdat_en_q <= do_rd;
                if (do_wr) wptr_q <= wptr_q + 1'b1;
                if (do_rd) begin
                    rptr_q <= rptr_q + 1'b1;
                    rdat_q <= mem_q[rptr_q];
                end
                case ({do_wr, do_rd})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;

    state_e            state_q;
    logic              dest_q;
    logic [LenW-1:0]   len_q;
    logic              ovf_q;
    logic              in_rd, route_dest, route_wr, dest_nfull;

    always_comb begin
        dest_nfull = dest_q ? n_full[2] : n_full[1];
        in_rd      = 1'b0;
        unique case (state_q)
            // Both output FIFOs must have room before a new message starts.
            StIdle:  in_rd = ~empty[0] & ~n_full[1] & ~n_full[2];
            StHdr:   in_rd = 1'b0;
            // At most one input read in flight keeps output writes within N_FULL margin.
            StPay:   in_rd = ~empty[0] & ~dest_nfull & ~rdat_en[0];
            default: in_rd = 1'b0;
        endcase
        // While in StHdr the destination comes straight from the returning header.
        route_dest = (state_q == StHdr) ? rdat[0][data_width-1] : dest_q;
        route_wr   = rdat_en[0] & (state_q != StIdle);

        wen     = {route_wr & route_dest, route_wr & ~route_dest, I_DAT_EN};
        wdat    = {rdat[0], rdat[0], I_DAT};
        ren     = {~B_BUSY, ~A_BUSY, in_rd};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            dest_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_rd) state_q <= StHdr;
                end
                StHdr: begin
                    if (rdat_en[0]) begin
                        dest_q  <= rdat[0][data_width-1];
                        len_q   <= rdat[0][LenW-1:0];
                        state_q <= (rdat[0][LenW-1:0] == '0) ? StIdle : StPay;
                    end
                end
                StPay: begin
                    if (rdat_en[0]) begin
                        len_q <= len_q - 1'b1;
                        if (len_q == LenW'(1)) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) ovf_q <= 1'b0;
        else       ovf_q <= I_DAT_EN & full[0];
    end

    assign I_N_FULL = n_full[0];
    assign OVF      = ovf_q;
    assign A_DAT_EN = rdat_en[1];
    assign A_DAT    = rdat[1];
    assign B_DAT_EN = rdat_en[2];
    assign B_DAT    = rdat[2];

endmodule

// File: tb/tb_msg_split.sv
// Directed bench for msg_split: routing, latency, zero-length messages, backpressure,
// overflow, head-of-line blocking and mid-message reset.
module tb_msg_split;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       I_DAT_EN;
    logic [7:0] I_DAT;
    logic       I_N_FULL;
    logic       A_DAT_EN;
    logic [7:0] A_DAT;
    logic       A_BUSY;
    logic       B_DAT_EN;
    logic [7:0] B_DAT;
    logic       B_BUSY;
    logic       OVF;

    msg_split #(.data_width(8), .adr_width(3)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .I_DAT_EN (I_DAT_EN),
        .I_DAT    (I_DAT),
        .I_N_FULL (I_N_FULL),
        .A_DAT_EN (A_DAT_EN),
        .A_DAT    (A_DAT),
        .A_BUSY   (A_BUSY),
        .B_DAT_EN (B_DAT_EN),
        .B_DAT    (B_DAT),
        .B_BUSY   (B_BUSY),
        .OVF      (OVF)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ovf_cnt  = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         qa_cyc[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // Output capture, sampled mid-cycle.
    always @(negedge CLK) begin
        if (A_DAT_EN) begin
            qa.push_back(A_DAT);
            qa_cyc.push_back(cyc);
        end
        if (B_DAT_EN) qb.push_back(B_DAT);
        if (OVF) ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input logic [7:0] got[$], input int base,
                             input logic [7:0] exp[$]);
        check({tag, "_len"}, got.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got.size())
                check($sformatf("%s[%0d]", tag, i), got[base + i], exp[i]);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one byte; optionally hold off while I_N_FULL is high (bounded).
    task automatic send(input logic [7:0] b, input bit honour);
        int n;
        n = 0;
        while (honour && I_N_FULL && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) check("n_full_wait", I_N_FULL, 0);
        I_DAT_EN = 1'b1;
        I_DAT    = b;
        tick();
        I_DAT_EN = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_a[$];
        logic [7:0] exp_b[$];
        int         a0, b0, o0, wcyc;

        RESET    = 1'b1;
        I_DAT_EN = 1'b0;
        I_DAT    = 8'h00;
        A_BUSY   = 1'b0;
        B_BUSY   = 1'b0;
        wait_cycles(3);
        check("reset_outputs", {I_N_FULL, A_DAT_EN, B_DAT_EN, OVF, A_DAT, B_DAT}, 0);
        RESET = 1'b0;
        wait_cycles(2);

        // Routing and header-to-output latency
        a0 = qa.size(); b0 = qb.size();
        wcyc = cyc;
        send(8'h02, 1'b1);
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b1);
        send(8'h81, 1'b1);
        send(8'hCC, 1'b1);
        wait_cycles(30);
        exp_a = '{8'h02, 8'hAA, 8'hBB};
        exp_b = '{8'h81, 8'hCC};
        check_seq("route_a", qa, a0, exp_a);
        check_seq("route_b", qb, b0, exp_b);
        if (qa_cyc.size() > a0) check("latency", qa_cyc[a0] - wcyc, 4);
        else check("latency_seen", qa_cyc.size(), a0 + 1);

        // Zero-length messages, then a normal message to confirm the FSM is idle again
        a0 = qa.size(); b0 = qb.size();
        send(8'h00, 1'b1);
        send(8'h80, 1'b1);
        send(8'h01, 1'b1);
        send(8'h33, 1'b1);
        wait_cycles(30);
        exp_a = '{8'h00, 8'h01, 8'h33};
        exp_b = '{8'h80};
        check_seq("zero_a", qa, a0, exp_a);
        check_seq("zero_b", qb, b0, exp_b);

        // Backpressure: maximum-length message to a busy A sink
        a0 = qa.size(); o0 = ovf_cnt;
        A_BUSY = 1'b1;
        fork
            begin
                send(8'h7F, 1'b1);
                for (int i = 0; i < 127; i++) send(8'(i), 1'b1);
            end
            begin
                wait_cycles(100);
                check("bp_no_out_busy", qa.size() - a0, 0);
                check("bp_a_bound", dut.fifo_cnt[1] <= 8, 1);
                A_BUSY = 1'b0;
            end
        join
        wait_cycles(500);
        exp_a = '{8'h7F};
        for (int i = 0; i < 127; i++) exp_a.push_back(8'(i));
        check_seq("bp_a", qa, a0, exp_a);
        check("bp_no_ovf", ovf_cnt - o0, 0);

        // Overflow: fill A FIFO to N_FULL, then burst 12 bytes into the blocked input FIFO
        a0 = qa.size();
        A_BUSY = 1'b1;
        send(8'h05, 1'b1);
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        wait_cycles(20);
        o0 = ovf_cnt;
        send(8'h07, 1'b0);
        for (int i = 0; i < 7; i++) send(8'h10 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), 1'b0);
        wait_cycles(3);
        check("ovf_pulses", ovf_cnt - o0, 4);
        check("ovf_in_count", dut.fifo_cnt[0], 8);
        check("ovf_no_out_busy", qa.size() - a0, 0);
        A_BUSY = 1'b0;
        wait_cycles(100);
        exp_a = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07};
        for (int i = 0; i < 7; i++) exp_a.push_back(8'h10 + 8'(i));
        check_seq("ovf_a", qa, a0, exp_a);

        // Head-of-line blocking: a stalled A message holds back a queued B message
        a0 = qa.size(); b0 = qb.size();
        A_BUSY = 1'b1;
        fork
            begin
                send(8'h08, 1'b1);
                for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1'b1);
                send(8'h82, 1'b1);
                send(8'h11, 1'b1);
                send(8'h22, 1'b1);
            end
            begin
                wait_cycles(60);
                check("block_no_b", qb.size() - b0, 0);
                check("block_no_a", qa.size() - a0, 0);
                A_BUSY = 1'b0;
            end
        join
        wait_cycles(100);
        exp_a = '{8'h08};
        for (int i = 0; i < 8; i++) exp_a.push_back(8'h20 + 8'(i));
        exp_b = '{8'h82, 8'h11, 8'h22};
        check_seq("block_a", qa, a0, exp_a);
        check_seq("block_b", qb, b0, exp_b);

        // Reset in the middle of a payload
        A_BUSY = 1'b1;
        send(8'h05, 1'b1);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        wait_cycles(10);
        check("pre_reset_a_dat", A_DAT, 8'h27);
        RESET = 1'b1;
        #1;
        check("reset_mid_outputs", {I_N_FULL, A_DAT_EN, B_DAT_EN, OVF, A_DAT, B_DAT}, 0);
        tick();
        RESET  = 1'b0;
        A_BUSY = 1'b0;
        wait_cycles(2);
        a0 = qa.size(); b0 = qb.size();
        send(8'h01, 1'b1);
        send(8'h55, 1'b1);
        wait_cycles(30);
        exp_a = '{8'h01, 8'h55};
        check_seq("post_reset_a", qa, a0, exp_a);
        check("post_reset_b", qb.size() - b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
